// File: rtl/pc_adder_if.sv
// Fetch-to-decode PC bus: fetch-side inputs plus the combinational and
// registered results produced by pc_adder.
interface pc_adder_if #(
   parameter int unsigned WIDTH = 32
);
   logic [WIDTH-1:0] PC_Cur;
   logic             valid_in;
   logic             stall;
   logic [WIDTH-1:0] PC_Next;
   logic             wrap;
   logic             misaligned;
   logic [WIDTH-1:0] PC_Cur_q;
   logic [WIDTH-1:0] PC_Next_q;
   logic             valid_q;

   modport master (
      output PC_Cur, valid_in, stall,
      input  PC_Next, wrap, misaligned, PC_Cur_q, PC_Next_q, valid_q
   );

   modport slave (
      input  PC_Cur, valid_in, stall,
      output PC_Next, wrap, misaligned, PC_Cur_q, PC_Next_q, valid_q
   );
endinterface

// File: rtl/pc_adder.sv
// Fetch-stage PC incrementer with a one-stage (PC, PC+INC) pipeline register
// for decode, plus carry-out and misalignment flags for trap logic.
module pc_adder #(
   parameter int unsigned      WIDTH        = 32,
   parameter int unsigned      INC          = 4,
   parameter logic [WIDTH-1:0] RESET_VECTOR = '0
) (
   input logic        clk,
   input logic        rst,
   pc_adder_if.slave  bus
);

   logic [WIDTH:0] sum;

   // Extra top bit of the sum is the carry out.
   always_comb begin
      sum            = {1'b0, bus.PC_Cur} + (WIDTH+1)'(INC);
      bus.PC_Next    = sum[WIDTH-1:0];
      bus.wrap       = sum[WIDTH];
      bus.misaligned = |bus.PC_Cur[1:0];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         bus.PC_Cur_q  <= RESET_VECTOR;
         bus.PC_Next_q <= RESET_VECTOR + WIDTH'(INC);
         bus.valid_q   <= 1'b0;
      end else if (!bus.stall) begin
         bus.PC_Cur_q  <= bus.PC_Cur;
         bus.PC_Next_q <= bus.PC_Next;
         bus.valid_q   <= bus.valid_in;
      end
   end

endmodule

// File: tb/tb_pc_adder.sv
// Self-checking bench for pc_adder: directed cases then randomized traffic
// against an arithmetic reference model.
module tb_pc_adder;
   localparam int unsigned      WIDTH = 32;
   localparam int unsigned      INC   = 4;
   localparam logic [WIDTH-1:0] RV    = 32'h8000_0000;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int unsigned n_checks = 0;
   int unsigned n_pass   = 0;

   logic [WIDTH-1:0] m_cur, m_next;
   logic             m_valid;

   pc_adder_if #(.WIDTH(WIDTH)) bus ();

   pc_adder #(.WIDTH(WIDTH), .INC(INC), .RESET_VECTOR(RV)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [WIDTH-1:0] got,
                        input logic [WIDTH-1:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   function automatic longint unsigned ref_sum(input logic [WIDTH-1:0] pc);
      return longint'(pc) + longint'(INC);
   endfunction

   // Combinational expectations straight from the arithmetic definition.
   task automatic check_comb(input string tag);
      longint unsigned s;
      s = ref_sum(bus.PC_Cur);
      check({tag, ".next"}, bus.PC_Next, WIDTH'(s % (64'd1 << WIDTH)));
      check({tag, ".wrap"}, WIDTH'(bus.wrap), WIDTH'(s >= (64'd1 << WIDTH)));
      check({tag, ".mis"}, WIDTH'(bus.misaligned), WIDTH'(bus.PC_Cur % 4 != 0));
   endtask

   task automatic check_regs(input string tag);
      check({tag, ".cur_q"}, bus.PC_Cur_q, m_cur);
      check({tag, ".next_q"}, bus.PC_Next_q, m_next);
      check({tag, ".valid_q"}, WIDTH'(bus.valid_q), WIDTH'(m_valid));
      check({tag, ".pair"}, bus.PC_Next_q, WIDTH'(ref_sum(bus.PC_Cur_q) % (64'd1 << WIDTH)));
   endtask

   // One clock: the model absorbs the inputs present at the edge.
   task automatic tick(input string tag);
      @(posedge clk);
      if (rst) begin
         m_cur = RV; m_next = WIDTH'(ref_sum(RV)); m_valid = 1'b0;
      end else if (!bus.stall) begin
         m_cur = bus.PC_Cur; m_next = WIDTH'(ref_sum(bus.PC_Cur)); m_valid = bus.valid_in;
      end
      #1;
      check_regs(tag);
   endtask

   initial begin
      logic [WIDTH-1:0] dir_pc [5];
      dir_pc = '{32'h0, 32'h4, 32'd100, 32'hFFFF_FFFC, 32'h0000_0102};

      bus.PC_Cur = '0; bus.valid_in = 1'b1; bus.stall = 1'b1; rst = 1'b1;
      #1;
      tick("reset");
      rst = 1'b0;

      foreach (dir_pc[i]) begin
         bus.PC_Cur = dir_pc[i];
         #10;
         check_comb($sformatf("dir%0d", i));
      end
      check("dir.ffc_next", bus.PC_Next, 32'h106);

      bus.stall = 1'b0; bus.valid_in = 1'b1; bus.PC_Cur = 32'h40;
      tick("cap40");
      check("cap40.lit", bus.PC_Next_q, 32'h44);
      bus.stall = 1'b1; bus.PC_Cur = 32'h80; bus.valid_in = 1'b0;
      for (int i = 0; i < 3; i++) tick($sformatf("stall%0d", i));
      check("stall.lit", bus.PC_Cur_q, 32'h40);
      rst = 1'b1;
      tick("rst_stall");
      rst = 1'b0; bus.stall = 1'b0;

      for (int i = 0; i < 300; i++) begin
         case ($urandom_range(0, 3))
            0: bus.PC_Cur = 32'hFFFF_FFF0 | WIDTH'($urandom_range(0, 15));
            1: bus.PC_Cur = $urandom & ~32'h3;
            default: bus.PC_Cur = $urandom;
         endcase
         bus.valid_in = 1'($urandom);
         bus.stall    = ($urandom_range(0, 3) == 0);
         rst          = ($urandom_range(0, 15) == 0);
         #1;
         check_comb($sformatf("rnd%0d", i));
         tick($sformatf("rnd%0d", i));
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
